// File: rtl/io_owner_pkg.sv
// Shared types and helpers for the Caravel user IO pad owner sequencer.
// Holds the handover state encoding, default timing and one-hot helpers.
package io_owner_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        RESET,
        RUN
    } state_t;

    localparam int DEF_GUARD_CYCLES = 16;
    localparam int DEF_RESET_CYCLES = 8;
    localparam int MAX_PROJ         = 32;

    function automatic logic onehot_valid(input logic [MAX_PROJ-1:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

    function automatic logic [4:0] onehot2idx(input logic [MAX_PROJ-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_PROJ; i++) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/io_owner_pad_mux.sv
// Registered NUM_PROJ:1 one-hot pad mux; park (or an empty select) forces out=0, oeb=1s.
// Ports: clk, rst_n, park, sel (one-hot), proj_out/proj_oeb (packed), pad_out/pad_oeb.
module io_owner_pad_mux
    import io_owner_pkg::*;
#(
    parameter int NUM_PROJ = 4,
    parameter int IO_W     = 38
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     park,
    input  logic [NUM_PROJ-1:0]      sel,
    input  logic [NUM_PROJ*IO_W-1:0] proj_out,
    input  logic [NUM_PROJ*IO_W-1:0] proj_oeb,
    output logic [IO_W-1:0]          pad_out,
    output logic [IO_W-1:0]          pad_oeb
);

    logic [4:0]      idx;
    logic            sel_ok;
    logic [IO_W-1:0] mux_out;
    logic [IO_W-1:0] mux_oeb;

    always_comb begin
        idx     = onehot2idx(32'(sel));
        sel_ok  = onehot_valid(32'(sel));
        mux_out = '0;
        mux_oeb = '1;
        if (!park && sel_ok) begin
            for (int k = 0; k < NUM_PROJ; k++) begin
                if (k == int'(idx)) begin
                    mux_out = proj_out[k*IO_W +: IO_W];
                    mux_oeb = proj_oeb[k*IO_W +: IO_W];
                end
            end
        end
    end

    // Pads are always driven from a flop: no combinational path from projects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_out <= '0;
            pad_oeb <= '1;
        end else begin
            pad_out <= mux_out;
            pad_oeb <= mux_oeb;
        end
    end

endmodule

// File: rtl/io_owner_sequencer.sv
// Hands the user IO pads between wrapped projects: park, reset incoming owner, then connect.
// Ports: wb_clk_i/wb_rst_n, active_i request, proj_io_* buses, io_* pads, status outputs.
module io_owner_sequencer
    import io_owner_pkg::*;
#(
    parameter int NUM_PROJ     = 4,
    parameter int IO_W         = 38,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n,
    input  logic [NUM_PROJ-1:0]      active_i,
    input  logic [NUM_PROJ*IO_W-1:0] proj_io_out_i,
    input  logic [NUM_PROJ*IO_W-1:0] proj_io_oeb_i,
    output logic [IO_W-1:0]          io_out_o,
    output logic [IO_W-1:0]          io_oeb_o,
    output logic [NUM_PROJ-1:0]      proj_rst_n_o,
    output logic [NUM_PROJ-1:0]      owner_o,
    output logic                     busy_o,
    output logic                     req_err_o
);

    localparam int CNT_MAX = (GUARD_CYCLES > RESET_CYCLES) ?
                             GUARD_CYCLES : RESET_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] G_LOAD = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] R_LOAD = CW'(RESET_CYCLES - 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [NUM_PROJ-1:0] req_q;
    logic [NUM_PROJ-1:0] req_prev;
    logic [NUM_PROJ-1:0] nxt;
    logic [NUM_PROJ-1:0] owner_q;
    logic [NUM_PROJ-1:0] prst_q;
    logic                busy_q;
    logic                err_q;

    logic                stable;
    logic                req_ok;
    logic                multi;
    logic [NUM_PROJ-1:0] tgt;
    logic                leave_run;
    logic                park;

    // A multi-hot request qualifies as "no owner".
    assign stable    = (req_q == req_prev);
    assign req_ok    = onehot_valid(32'(req_q));
    assign multi     = (req_q != '0) && !req_ok;
    assign tgt       = req_ok ? req_q : '0;
    assign leave_run = (state == RUN) && stable && (tgt != owner_q);

    // Park on the exit edge too, so pads never outlive RUN by a cycle.
    assign park = (state != RUN) || leave_run;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            req_q    <= '0;
            req_prev <= '0;
            nxt      <= '0;
            owner_q  <= '0;
            prst_q   <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            req_q    <= active_i;
            req_prev <= req_q;

            if (multi) begin
                err_q <= 1'b1;
            end else if (stable && (req_q == '0)) begin
                err_q <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (stable && (tgt != '0)) begin
                        state  <= GUARD;
                        nxt    <= tgt;
                        cnt    <= G_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                GUARD: begin
                    if (stable && (tgt != nxt)) begin
                        nxt <= tgt;
                        cnt <= G_LOAD;
                    end else if (cnt == '0) begin
                        if (nxt == '0) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= RESET;
                            cnt   <= R_LOAD;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESET: begin
                    // An aborted incoming project simply stays in reset.
                    if (stable && (tgt != nxt)) begin
                        state <= GUARD;
                        nxt   <= tgt;
                        cnt   <= G_LOAD;
                    end else if (cnt == '0) begin
                        state   <= RUN;
                        owner_q <= nxt;
                        prst_q  <= nxt;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RUN: begin
                    if (leave_run) begin
                        state   <= GUARD;
                        nxt     <= tgt;
                        owner_q <= '0;
                        prst_q  <= '0;
                        cnt     <= G_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    io_owner_pad_mux #(
        .NUM_PROJ (NUM_PROJ),
        .IO_W     (IO_W)
    ) u_pad_mux (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n),
        .park     (park),
        .sel      (owner_q),
        .proj_out (proj_io_out_i),
        .proj_oeb (proj_io_oeb_i),
        .pad_out  (io_out_o),
        .pad_oeb  (io_oeb_o)
    );

    assign proj_rst_n_o = prst_q;
    assign owner_o      = owner_q;
    assign busy_o       = busy_q;
    assign req_err_o    = err_q;

endmodule

// File: tb/tb_io_owner_sequencer.sv
// Directed vector bench for io_owner_sequencer (4 projects, 38 pads, 16/8 timing).
// Vectors give edges to advance and the outputs expected afterwards.
module tb_io_owner_sequencer;

    localparam int NP = 4;
    localparam int W  = 38;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NP-1:0]   active = '0;
    logic [NP*W-1:0] pout;
    logic [NP*W-1:0] poeb;
    logic [W-1:0]    io_out;
    logic [W-1:0]    io_oeb;
    logic [NP-1:0]   prst;
    logic [NP-1:0]   owner;
    logic            busy;
    logic            err;

    logic [W-1:0] pat_out [NP];
    logic [W-1:0] pat_oeb [NP];

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [NP-1:0] act;
        int            n;
        logic [NP-1:0] own;
        logic [NP-1:0] prst;
        logic          busy;
        logic          err;
        logic          drive;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    io_owner_sequencer #(
        .NUM_PROJ     (NP),
        .IO_W         (W),
        .GUARD_CYCLES (16),
        .RESET_CYCLES (8)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_n      (rst_n),
        .active_i      (active),
        .proj_io_out_i (pout),
        .proj_io_oeb_i (poeb),
        .io_out_o      (io_out),
        .io_oeb_o      (io_oeb),
        .proj_rst_n_o  (prst),
        .owner_o       (owner),
        .busy_o        (busy),
        .req_err_o     (err)
    );

    function automatic vec_t mk(logic [NP-1:0] act, int n,
                                logic [NP-1:0] own, logic [NP-1:0] pr,
                                logic b, logic e, logic d);
        vec_t v;
        v.act   = act;
        v.n     = n;
        v.own   = own;
        v.prst  = pr;
        v.busy  = b;
        v.err   = e;
        v.drive = d;
        return v;
    endfunction

    task automatic check(string name, logic [NP-1:0] e_own,
                         logic [NP-1:0] e_prst, logic e_busy,
                         logic e_err, logic e_drive);
        logic [W-1:0] e_out;
        logic [W-1:0] e_oeb;
        e_out = '0;
        e_oeb = '1;
        if (e_drive) begin
            for (int k = 0; k < NP; k++) begin
                if (e_own[k]) begin
                    e_out = pat_out[k];
                    e_oeb = pat_oeb[k];
                end
            end
        end
        n_vec++;
        if (owner !== e_own || prst !== e_prst || busy !== e_busy ||
            err !== e_err || io_out !== e_out || io_oeb !== e_oeb) begin
            n_bad++;
            $display("FAIL %s: got own=%b rst_n=%b busy=%b err=%b out=%h oeb=%h; want own=%b rst_n=%b busy=%b err=%b out=%h oeb=%h",
                     name, owner, prst, busy, err, io_out, io_oeb,
                     e_own, e_prst, e_busy, e_err, e_out, e_oeb);
        end
    endtask

    initial begin
        pat_out[0] = 38'h15_5555_5555;
        pat_out[1] = 38'h2A_AAAA_AAAA;
        pat_out[2] = 38'h0F_0F0F_0F0F;
        pat_out[3] = 38'h30_F0F0_1234;
        pat_oeb[0] = 38'h00_0000_0000;
        pat_oeb[1] = 38'h3F_FFFF_0000;
        pat_oeb[2] = 38'h00_0000_FFFF;
        pat_oeb[3] = 38'h3F_0000_0000;
        for (int k = 0; k < NP; k++) begin
            pout[k*W +: W] = pat_out[k];
            poeb[k*W +: W] = pat_oeb[k];
        end

        // 1: 0001 from IDLE; RUN on edge 3+16+8, pads one edge later
        tbl.push_back(mk(4'b0001,  2, 4'b0000, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(4'b0001,  1, 4'b0000, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(4'b0001, 23, 4'b0000, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(4'b0001,  1, 4'b0001, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(4'b0001,  1, 4'b0001, 4'b0001, 0, 0, 1));
        // 2: handover 0001 -> 0100
        tbl.push_back(mk(4'b0100,  2, 4'b0001, 4'b0001, 0, 0, 1));
        tbl.push_back(mk(4'b0100,  1, 4'b0000, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(4'b0100, 23, 4'b0000, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(4'b0100,  1, 4'b0100, 4'b0100, 0, 0, 0));
        tbl.push_back(mk(4'b0100,  1, 4'b0100, 4'b0100, 0, 0, 1));
        // release to zero: GUARD then IDLE
        tbl.push_back(mk(4'b0000,  3, 4'b0000, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(4'b0000, 15, 4'b0000, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(4'b0000,  1, 4'b0000, 4'b0000, 0, 0, 0));
        // 3: 0100 then 1000 when guard count is 5
        tbl.push_back(mk(4'b0100, 13, 4'b0000, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(4'b1000, 14, 4'b0000, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(4'b1000, 12, 4'b0000, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(4'b1000,  1, 4'b1000, 4'b1000, 0, 0, 0));
        tbl.push_back(mk(4'b1000,  1, 4'b1000, 4'b1000, 0, 0, 1));
        // 4: multi-hot request
        tbl.push_back(mk(4'b0110,  1, 4'b1000, 4'b1000, 0, 0, 1));
        tbl.push_back(mk(4'b0110,  1, 4'b1000, 4'b1000, 0, 1, 1));
        tbl.push_back(mk(4'b0110,  1, 4'b0000, 4'b0000, 1, 1, 0));
        tbl.push_back(mk(4'b0110, 16, 4'b0000, 4'b0000, 0, 1, 0));
        tbl.push_back(mk(4'b0000,  2, 4'b0000, 4'b0000, 0, 1, 0));
        tbl.push_back(mk(4'b0000,  1, 4'b0000, 4'b0000, 0, 0, 0));
        // 5: glitch while running
        tbl.push_back(mk(4'b0001, 27, 4'b0001, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(4'b0001,  1, 4'b0001, 4'b0001, 0, 0, 1));
        tbl.push_back(mk(4'b0010,  1, 4'b0001, 4'b0001, 0, 0, 1));
        tbl.push_back(mk(4'b0001,  1, 4'b0001, 4'b0001, 0, 0, 1));
        tbl.push_back(mk(4'b0001,  1, 4'b0001, 4'b0001, 0, 0, 1));
        tbl.push_back(mk(4'b0001,  1, 4'b0001, 4'b0001, 0, 0, 1));
        tbl.push_back(mk(4'b0001,  1, 4'b0001, 4'b0001, 0, 0, 1));

        #12;
        check("reset", '0, '0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            active = tbl[i].act;
            repeat (tbl[i].n) @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), tbl[i].own, tbl[i].prst,
                  tbl[i].busy, tbl[i].err, tbl[i].drive);
        end

        // 6a: async reset mid-RUN, seen before the next edge
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_run", '0, '0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 6b: restart, then reset again mid-RESET
        repeat (20) @(posedge clk);
        #1;
        check("restart_in_reset", '0, '0, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_reset", '0, '0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("rst_held", '0, '0, 0, 0, 0);
        rst_n = 1'b1;

        // full timing again after release
        repeat (26) @(posedge clk);
        #1;
        check("relaunch_busy", '0, '0, 1, 0, 0);
        @(posedge clk);
        #1;
        check("relaunch_run", 4'b0001, 4'b0001, 0, 0, 0);
        @(posedge clk);
        #1;
        check("relaunch_pads", 4'b0001, 4'b0001, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/io_owner_sequencer.md
Name: io_owner_sequencer

Overview:
Shares the 38 Caravel user IO pads between up to NUM_PROJ wrapped projects in the user_project_wrapper. A one-hot `active` word from the logic analyser selects the owner. On every change of owner the block parks all pads as inputs for a guard period, then holds the incoming project in reset, and only then connects its io_out/io_oeb to the pads. It sits between the wrapped project instances and the io_out/io_oeb wrapper ports.

Parameters:
NUM_PROJ, 4, number of wrapped projects sharing the pads (1..32)
IO_W, 38, pad count (`MPRJ_IO_PADS`)
GUARD_CYCLES, 16, cycles all pads are held input-only (oeb=1, out=0) on handover (>=1)
RESET_CYCLES, 8, cycles the incoming project's reset is held asserted (>=1)

Ports:
wb_clk_i  input  1  sole clock
wb_rst_n  input  1  asynchronous active-low reset
active_i  input  NUM_PROJ  owner request, one-hot or zero (from la_data_in[NUM_PROJ-1:0])
proj_io_out_i  input  NUM_PROJ*IO_W  concatenated project io_out; project k at [k*IO_W +: IO_W]
proj_io_oeb_i  input  NUM_PROJ*IO_W  concatenated project io_oeb, same packing
io_out_o  output  IO_W  pad outputs
io_oeb_o  output  IO_W  pad output-enable-bar
proj_rst_n_o  output  NUM_PROJ  per-project active-low reset
owner_o  output  NUM_PROJ  one-hot current owner; zero when no owner
busy_o  output  1  high in GUARD or RESET
req_err_o  output  1  sticky: a multi-hot request was seen

Behaviour:
- Reset value of every output, applied asynchronously: io_out_o=0, io_oeb_o=all 1s, proj_rst_n_o=0, owner_o=0, busy_o=0, req_err_o=0. State resets to IDLE.
- Request qualification:
  - active_i is registered into req_q.
  - A request is valid only if req_q equals the previous req_q (stable for 2 consecutive cycles).
  - Multi-hot req_q is treated as zero and sets req_err_o.
  - req_err_o clears only when a stable zero request is seen.
- tgt = the qualified request (one-hot or 0).
- States:
  - IDLE: no owner. If stable tgt!=0, go to GUARD, latch tgt into nxt, load cnt=GUARD_CYCLES-1.
  - GUARD: pads parked.
    - cnt decrements each cycle.
    - If stable tgt!=nxt, relatch nxt and reload cnt (guard restarts).
    - At cnt==0: if nxt==0 go to IDLE; else go to RESET and load cnt=RESET_CYCLES-1.
  - RESET: pads parked; proj_rst_n_o[nxt]=0.
    - If stable tgt!=nxt, go to GUARD with the new nxt and reload the guard count. The aborted project stays in reset.
    - At cnt==0 go to RUN, with owner=nxt.
  - RUN: owner's reset released; pads driven from the owner.
    - If stable tgt!=owner, go to GUARD with nxt=tgt and owner cleared in the same transition.
- proj_rst_n_o[k]=1 only in RUN and only for k==owner. All others are 0. Non-owners are always held in reset.
- Pad path:
  - In RUN, io_out_o/io_oeb_o = registered copy of the owner's slice (1 cycle latency from proj_*_i).
  - In all other states: out=0, oeb=1.
  - Register the mux output; no combinational path from proj_*_i to the pads.
- Latency:
  - From an active_i change to the first RUN cycle: 2 (capture+stability) + GUARD_CYCLES + RESET_CYCLES cycles.
  - The pads show owner data one cycle after entering RUN.
- owner_o is updated on entry to and exit from RUN. busy_o = (state==GUARD || state==RESET).
- Counter width: $clog2(max(GUARD_CYCLES,RESET_CYCLES)+1). Counters never wrap; the count is reloaded on every entry.
- A request equal to the current owner has no effect. A request in IDLE equal to zero has no effect.
- Reset asserted mid-handover aborts immediately to the reset values. No partial pad drive is allowed.

Decomposition:
- Package io_owner_pkg:
  - state enum {IDLE, GUARD, RESET, RUN}
  - default GUARD_CYCLES/RESET_CYCLES
  - function onehot_valid(vec) returning 1 for exactly one bit set
  - function onehot2idx
- One sub-module: io_owner_pad_mux, a parameterised registered NUM_PROJ:1 one-hot mux of IO_W-wide out/oeb with a park input forcing out=0, oeb=1s.

Test Plan:
1. Reset, active_i=0001 applied:
   - oeb stays all 1s for 2+16+8 cycles and proj_rst_n_o=0000 throughout; then proj_rst_n_o=0001 and owner_o=0001.
   - Next cycle io_out_o/io_oeb_o equal project 0's slice (e.g. out=38'h15_5555_5555, oeb=0).
2. Owner 0001 running, active_i→0100:
   - Within 2 cycles owner_o=0, proj_rst_n_o=0000, oeb all 1s.
   - After 16 guard + 8 reset cycles, owner_o=0100 and the pads mirror project 2.
3. During GUARD at cnt=5, active_i changes 0100→1000:
   - Guard restarts with a full 16 cycles.
   - Final owner is 1000; project 2 never leaves reset.
4. active_i=0110 (multi-hot):
   - req_err_o=1, state goes to GUARD then IDLE, pads stay parked.
   - active_i=0000 clears req_err_o after 2 cycles.
5. A 1-cycle glitch on active_i (0001→0010→0001) while in RUN: ignored. Owner unchanged, pads never park.
6. wb_rst_n pulsed low mid-RESET and mid-RUN:
   - Outputs go to reset values asynchronously within the same cycle.
   - After release the sequence restarts from IDLE with full guard and reset timing.
